// File: rtl/cnt_seq_checker.sv
// ---------------------------------------------------------------------------
// cnt_seq_checker
//   In-design checker for a free-running counter bus. When the trigger value
//   START_VAL is sampled, the next SEQ_LEN samples must each be the previous
//   value + 1, modulo 2**WIDTH. The result is reported as a one-cycle
//   pass/fail pulse, a snapshot of the most recent failure, and saturating
//   pass/fail counters.
//
// Ports
//   clk        sampling clock (posedge)
//   rst_n      asynchronous active-low reset
//   en         checker enable; dropping it aborts an attempt silently
//   cnt        counter value under check
//   clr_stats  synchronous clear of pass_count / fail_count
//   chk_active attempt in progress
//   pass_pulse one-cycle pulse, attempt completed correctly
//   fail_pulse one-cycle pulse, attempt failed
//   fail_exp   expected value at the most recent failure
//   fail_got   sampled value at the most recent failure
//   pass_count saturating pass counter
//   fail_count saturating fail counter
// ---------------------------------------------------------------------------
module cnt_seq_checker #(
  parameter int WIDTH     = 3,
  parameter int START_VAL = 0,
  parameter int SEQ_LEN   = 3,   // 1 .. 2**WIDTH-1
  parameter int STAT_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [WIDTH-1:0]  cnt,
  input  logic              clr_stats,
  output logic              chk_active,
  output logic              pass_pulse,
  output logic              fail_pulse,
  output logic [WIDTH-1:0]  fail_exp,
  output logic [WIDTH-1:0]  fail_got,
  output logic [STAT_W-1:0] pass_count,
  output logic [STAT_W-1:0] fail_count
);

  typedef enum logic {IDLE = 1'b0, CHECK = 1'b1} state_e;

  localparam logic [WIDTH-1:0]  START     = WIDTH'(START_VAL);
  localparam logic [WIDTH-1:0]  LAST_STEP = WIDTH'(SEQ_LEN);
  localparam logic [STAT_W-1:0] STAT_MAX  = {STAT_W{1'b1}};

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  step_q, step_d;
  logic              pass_q, pass_d;
  logic              fail_q, fail_d;
  logic [WIDTH-1:0]  fexp_q, fexp_d;
  logic [WIDTH-1:0]  fgot_q, fgot_d;
  logic [STAT_W-1:0] pcnt_q, pcnt_d;
  logic [STAT_W-1:0] fcnt_q, fcnt_d;

  // Expected sample for the current step; the WIDTH-bit add wraps for free.
  logic [WIDTH-1:0]  exp_val;
  assign exp_val = START + step_q;

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    pass_d  = 1'b0;
    fail_d  = 1'b0;
    fexp_d  = fexp_q;
    fgot_d  = fgot_q;
    case (state_q)
      IDLE: begin
        if (en && cnt == START) begin
          state_d = CHECK;
          step_d  = WIDTH'(1);
        end
      end
      CHECK: begin
        if (!en) begin
          // Silent abort: no pulse, no statistics.
          state_d = IDLE;
          step_d  = '0;
        end else if (cnt == exp_val) begin
          if (step_q == LAST_STEP) begin
            pass_d  = 1'b1;
            state_d = IDLE;
            step_d  = '0;
          end else begin
            step_d  = step_q + WIDTH'(1);
          end
        end else begin
          fail_d = 1'b1;
          fexp_d = exp_val;
          fgot_d = cnt;
          // The failing sample may itself be a fresh trigger: rearm on it.
          if (cnt == START) begin
            step_d = WIDTH'(1);
          end else begin
            state_d = IDLE;
            step_d  = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        step_d  = '0;
      end
    endcase
  end

  // Statistics: clear beats a coincident increment; both saturate.
  always_comb begin
    pcnt_d = pcnt_q;
    fcnt_d = fcnt_q;
    if (clr_stats) begin
      pcnt_d = '0;
      fcnt_d = '0;
    end else begin
      if (pass_d && pcnt_q != STAT_MAX) pcnt_d = pcnt_q + STAT_W'(1);
      if (fail_d && fcnt_q != STAT_MAX) fcnt_d = fcnt_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      step_q  <= '0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      fexp_q  <= '0;
      fgot_q  <= '0;
      pcnt_q  <= '0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      fexp_q  <= fexp_d;
      fgot_q  <= fgot_d;
      pcnt_q  <= pcnt_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign chk_active = (state_q == CHECK);
  assign pass_pulse = pass_q;
  assign fail_pulse = fail_q;
  assign fail_exp   = fexp_q;
  assign fail_got   = fgot_q;
  assign pass_count = pcnt_q;
  assign fail_count = fcnt_q;

endmodule

// File: tb/tb_cnt_seq_checker.sv
// ---------------------------------------------------------------------------
// tb_cnt_seq_checker
//   Two checker instances share one stimulus stream: u0 with defaults
//   (trigger 0, 8-bit stats) and u1 with trigger 6 and 2-bit stats, so the
//   wrap-around and saturation cases are exercised on the same bus.
//   Every cycle both are compared to a reference model that tracks
//   "next expected value" and "samples left" per attempt.
// ---------------------------------------------------------------------------
module tb_cnt_seq_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [2:0] cnt = '0;
  logic       clr = 1'b0;

  logic       act0, pp0, fp0, act1, pp1, fp1;
  logic [2:0] fe0, fg0, fe1, fg1;
  logic [7:0] pc0, fc0;
  logic [1:0] pc1, fc1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cnt_seq_checker #(.WIDTH(3), .START_VAL(0), .SEQ_LEN(3), .STAT_W(8)) u0 (
    .clk(clk), .rst_n(rst_n), .en(en), .cnt(cnt), .clr_stats(clr),
    .chk_active(act0), .pass_pulse(pp0), .fail_pulse(fp0),
    .fail_exp(fe0), .fail_got(fg0), .pass_count(pc0), .fail_count(fc0));

  cnt_seq_checker #(.WIDTH(3), .START_VAL(6), .SEQ_LEN(3), .STAT_W(2)) u1 (
    .clk(clk), .rst_n(rst_n), .en(en), .cnt(cnt), .clr_stats(clr),
    .chk_active(act1), .pass_pulse(pp1), .fail_pulse(fp1),
    .fail_exp(fe1), .fail_got(fg1), .pass_count(pc1), .fail_count(fc1));

  typedef struct {
    bit act; int nxt; int left;
    bit pp; bit fp; int fe; int fg; int pc; int fc;
  } mdl_t;

  mdl_t m0, m1;

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.act = 0; m.nxt = 0; m.left = 0; m.pp = 0; m.fp = 0;
    m.fe = 0; m.fg = 0; m.pc = 0; m.fc = 0;
    return m;
  endfunction

  // One sampling edge of the spec: trigger opens an attempt expecting
  // start+1 next, each good sample moves the expectation on by one.
  function automatic mdl_t mdl_step(mdl_t mi, bit e, int c, bit cl,
                                    int start, int seqlen, int smax);
    mdl_t m = mi;
    m.pp = 0; m.fp = 0;
    if (!m.act) begin
      if (e && c == start) begin
        m.act = 1; m.nxt = (start + 1) % 8; m.left = seqlen;
      end
    end else if (!e) begin
      m.act = 0;
    end else if (c == m.nxt) begin
      if (m.left == 1) begin m.pp = 1; m.act = 0; end
      else begin m.nxt = (m.nxt + 1) % 8; m.left--; end
    end else begin
      m.fp = 1; m.fe = m.nxt; m.fg = c;
      if (c == start) begin m.nxt = (start + 1) % 8; m.left = seqlen; end
      else m.act = 0;
    end
    if (cl) begin m.pc = 0; m.fc = 0; end
    else begin
      if (m.pp && m.pc < smax) m.pc++;
      if (m.fp && m.fc < smax) m.fc++;
    end
    return m;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("u0.act", 32'(act0), 32'(m0.act));
    chk("u0.pass", 32'(pp0), 32'(m0.pp));
    chk("u0.fail", 32'(fp0), 32'(m0.fp));
    chk("u0.fexp", 32'(fe0), m0.fe);
    chk("u0.fgot", 32'(fg0), m0.fg);
    chk("u0.pcnt", 32'(pc0), m0.pc);
    chk("u0.fcnt", 32'(fc0), m0.fc);
    chk("u1.act", 32'(act1), 32'(m1.act));
    chk("u1.pass", 32'(pp1), 32'(m1.pp));
    chk("u1.fail", 32'(fp1), 32'(m1.fp));
    chk("u1.fexp", 32'(fe1), m1.fe);
    chk("u1.fgot", 32'(fg1), m1.fg);
    chk("u1.pcnt", 32'(pc1), m1.pc);
    chk("u1.fcnt", 32'(fc1), m1.fc);
  endtask

  // Inputs change 1 time unit after the edge; outputs are checked there too.
  task automatic tick(input bit e, input int c, input bit cl);
    en = e; cnt = 3'(c); clr = cl;
    @(posedge clk);
    m0 = mdl_step(m0, e, c, cl, 0, 3, 255);
    m1 = mdl_step(m1, e, c, cl, 6, 3, 3);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    m0 = mdl_reset(); m1 = mdl_reset();
    check_all();
    #2 rst_n = 1'b1;
  endtask

  initial begin
    m0 = mdl_reset(); m1 = mdl_reset();
    #2;
    check_all();                          // reset state
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: free-running 0..7, four passes on u0, none failed
    for (int i = 0; i < 32; i++) begin
      tick(1, i % 8, 0);
      if (i % 8 == 3) chk("t1.pass_at3", 32'(pp0), 1);
    end
    chk("t1.pcnt", 32'(pc0), 4);
    chk("t1.fcnt", 32'(fc0), 0);

    // 2: skip 1 -> 4
    tick(1, 0, 0); tick(1, 1, 0); tick(1, 4, 0);
    chk("t2.fp", 32'(fp0), 1);
    chk("t2.fexp", 32'(fe0), 2);
    chk("t2.fgot", 32'(fg0), 4);
    tick(1, 5, 0);
    chk("t2.idle", 32'(act0), 0);

    // 3: failing sample is a trigger -> rearm
    tick(1, 0, 0); tick(1, 1, 0); tick(1, 0, 0);
    chk("t3.fp", 32'(fp0), 1);
    chk("t3.rearm", 32'(act0), 1);
    chk("t3.fexp", 32'(fe0), 2);
    tick(1, 1, 0); tick(1, 2, 0); tick(1, 3, 0);
    chk("t3.pass", 32'(pp0), 1);

    // 4: trigger 6 wraps through 7,0,1 on u1
    tick(1, 6, 0); tick(1, 7, 0); tick(1, 0, 0); tick(1, 1, 0);
    chk("t4.pass", 32'(pp1), 1);
    tick(1, 6, 0); tick(1, 7, 0); tick(1, 1, 0);
    chk("t4.fp", 32'(fp1), 1);
    chk("t4.fexp", 32'(fe1), 0);
    chk("t4.fgot", 32'(fg1), 1);

    // 5: en drop aborts silently, then async reset mid-attempt
    tick(1, 0, 0); tick(1, 1, 0); tick(0, 2, 0);
    chk("t5.abort", 32'(act0), 0);
    tick(1, 2, 0); tick(1, 3, 0);
    chk("t5.nopass", 32'(pp0), 0);
    tick(1, 0, 0);
    do_reset();
    chk("t5.rst_act", 32'(act0), 0);
    tick(1, 1, 0); tick(1, 2, 0);

    // 6: u1 fail counter saturates at 3, clear on a fail edge
    tick(1, 3, 1);
    for (int i = 0; i < 4; i++) begin tick(1, 6, 0); tick(1, 0, 0); end
    chk("t6.sat", 32'(fc1), 3);
    tick(1, 6, 0); tick(1, 2, 1);
    chk("t6.clr", 32'(fc1), 0);
    chk("t6.fp", 32'(fp1), 1);
    chk("t6.fexp", 32'(fe1), 7);
    chk("t6.fgot", 32'(fg1), 2);

    // Randomized: mostly counting, occasional jumps, enable drops, clears, resets
    begin
      int c = 0;
      for (int i = 0; i < 800; i++) begin
        c = ($urandom_range(99) < 80) ? (c + 1) % 8 : int'($urandom_range(7));
        tick($urandom_range(99) < 94, c, $urandom_range(99) < 3);
        if ($urandom_range(199) == 0) do_reset();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
